// File: rtl/jelly3_mipi_csi2_rx_packet_2lane.sv
// jelly3_mipi_csi2_rx_packet_2lane: 2-lane CSI-2 RX packet parser; define JELLY3_MIPI_CSI2_RX_ECC_CORRECT_EN for single-bit header ECC correction
module jelly3_mipi_csi2_rx_packet_2lane #(
    parameter DEVICE     = "RTL",
    parameter SIMULATION = "false",
    parameter DEBUG      = "false"
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_tuser,
    input  logic        s_tlast,
    input  logic [15:0] s_tdata,
    input  logic        s_tvalid,
    output logic        s_tready,
    output logic        m_tuser,
    output logic        m_tlast,
    output logic [15:0] m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic [7:0]  pkt_di,
    output logic [15:0] pkt_wc,
    output logic        frame_start,
    output logic        frame_end,
    output logic        line_start,
    output logic        line_end,
    output logic        ecc_error,
    output logic        crc_error,
    output logic        pkt_error
);
    typedef enum logic [2:0] {IDLE, HDR1, DATA, CRCW, DROP} state_t;

    localparam logic [5:0] ECC_TABLE [24] = '{
        6'h07, 6'h0b, 6'h0d, 6'h0e, 6'h13, 6'h15, 6'h16, 6'h19,
        6'h1a, 6'h1c, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2a, 6'h2c,
        6'h31, 6'h32, 6'h34, 6'h38, 6'h1f, 6'h2f, 6'h37, 6'h3b
    };

    function automatic logic [15:0] crc_word(input logic [15:0] c, input logic [15:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 16; i++) r = (r[0] ^ d[i]) ? ((r >> 1) ^ 16'h8408) : (r >> 1);
        return r;
    endfunction

    (* mark_debug = DEBUG *) state_t      state;
    state_t                               state_next;
    (* mark_debug = DEBUG *) logic [15:0] crc;
    logic [7:0]  di_r;
    logic [7:0]  wc_lo;
    logic [14:0] cnt;
    logic        first;
    logic        acc;
    logic [23:0] hdr;
    logic [23:0] hdr_fix;
    logic [5:0]  ecc;
    logic [5:0]  syn;
    logic        ecc_ok;
    logic        fs_n, fe_n, ls_n, le_n, ecc_err_n, crc_err_n, pkt_err_n;

    assign s_tready = (state == DATA) ? (!m_tvalid || m_tready) : 1'b1;
    assign acc      = s_tvalid && s_tready;

    // header ECC: syndrome of the assembled {WC, DI} against the received ECC byte
    always_comb begin
        hdr = {s_tdata[7:0], wc_lo, di_r};
        ecc = 6'h00;
        for (int i = 0; i < 24; i++) ecc = ecc ^ (hdr[i] ? ECC_TABLE[i] : 6'h00);
        syn     = ecc ^ s_tdata[13:8];
        hdr_fix = hdr;
`ifdef JELLY3_MIPI_CSI2_RX_ECC_CORRECT_EN
        for (int i = 0; i < 24; i++) if (syn == ECC_TABLE[i]) hdr_fix[i] = ~hdr[i];
        ecc_ok = (syn == 6'h00) || $onehot(syn) || (hdr_fix != hdr);
`else
        ecc_ok = (syn == 6'h00);
`endif
    end

    // next state and single-cycle event decode
    always_comb begin
        state_next = state;
        fs_n       = 1'b0;
        fe_n       = 1'b0;
        ls_n       = 1'b0;
        le_n       = 1'b0;
        ecc_err_n  = 1'b0;
        crc_err_n  = 1'b0;
        pkt_err_n  = 1'b0;
        case (state)
            IDLE: state_next = (acc && s_tuser) ? HDR1 : IDLE;
            HDR1: if (acc) begin
                if (!s_tuser) begin
                    pkt_err_n  = 1'b1;
                    state_next = IDLE;
                end else if (!ecc_ok) begin
                    ecc_err_n  = 1'b1;
                    state_next = s_tlast ? IDLE : DROP;
                end else if (hdr_fix[5:0] < 6'h10) begin
                    fs_n       = hdr_fix[5:0] == 6'h00;
                    fe_n       = hdr_fix[5:0] == 6'h01;
                    ls_n       = hdr_fix[5:0] == 6'h02;
                    le_n       = hdr_fix[5:0] == 6'h03;
                    pkt_err_n  = !s_tlast;
                    state_next = s_tlast ? IDLE : DROP;
                end else if (hdr_fix[23:8] == 16'h0000 || hdr_fix[8] || s_tlast) begin
                    pkt_err_n  = 1'b1;
                    state_next = s_tlast ? IDLE : DROP;
                end else begin
                    state_next = DATA;
                end
            end
            DATA: if (acc) begin
                if (s_tuser) begin
                    pkt_err_n  = 1'b1;
                    state_next = HDR1;
                end else if (s_tlast) begin
                    pkt_err_n  = 1'b1;
                    state_next = IDLE;
                end else if (cnt == 15'd1) begin
                    state_next = CRCW;
                end
            end
            CRCW: if (acc) begin
                crc_err_n  = s_tdata != crc;
                pkt_err_n  = !s_tlast;
                state_next = s_tlast ? IDLE : DROP;
            end
            DROP: state_next = (acc && s_tlast) ? IDLE : DROP;
            default: state_next = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        state <= reset ? IDLE : state_next;
    end

    // header capture, payload output stage, CRC accumulation and event pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            m_tvalid    <= 1'b0;
            m_tuser     <= 1'b0;
            m_tlast     <= 1'b0;
            m_tdata     <= 16'h0000;
            pkt_di      <= 8'h00;
            pkt_wc      <= 16'h0000;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            line_start  <= 1'b0;
            line_end    <= 1'b0;
            ecc_error   <= 1'b0;
            crc_error   <= 1'b0;
            pkt_error   <= 1'b0;
            di_r        <= 8'h00;
            wc_lo       <= 8'h00;
            cnt         <= 15'd0;
            crc         <= 16'hffff;
            first       <= 1'b0;
        end else begin
            frame_start <= fs_n;
            frame_end   <= fe_n;
            line_start  <= ls_n;
            line_end    <= le_n;
            ecc_error   <= ecc_err_n;
            crc_error   <= crc_err_n;
            pkt_error   <= pkt_err_n;
            if (acc && s_tuser && (state == IDLE || state == DATA)) begin
                di_r  <= s_tdata[7:0];
                wc_lo <= s_tdata[15:8];
            end
            if (state == HDR1) begin
                cnt   <= hdr_fix[23:9];
                crc   <= 16'hffff;
                first <= 1'b1;
                if (acc && s_tuser && ecc_ok) begin
                    pkt_di <= hdr_fix[7:0];
                    pkt_wc <= hdr_fix[23:8];
                end
            end
            if (state == DATA && acc && !s_tuser) begin
                m_tvalid <= 1'b1;
                m_tdata  <= s_tdata;
                m_tuser  <= first;
                m_tlast  <= s_tlast || cnt == 15'd1;
                first    <= 1'b0;
                cnt      <= cnt - 15'd1;
                crc      <= crc_word(crc, s_tdata);
            end else if (m_tready) begin
                m_tvalid <= 1'b0;
            end
        end
    end

    if (SIMULATION == "true") begin : g_sim
        // a payload word must never overwrite a stalled output word
        always_ff @(posedge clk) begin
            if (!reset && state == DATA && acc) assert (!m_tvalid || m_tready);
        end
    end
endmodule
